// File: rtl/serial_link_train_if.sv
// Receiver-side training handshake bundle for serial_link_train.
// master drives the receiver inputs; slave is the trainer itself.
interface serial_link_train_if;
    logic        enable;
    logic        retrain;
    logic [63:0] word;
    logic        word_valid;
    logic        phy_init;
    logic [5:0]  slip;
    logic [2:0]  state;
    logic        link_up;
    logic        fail;
    logic [63:0] data;
    logic        data_valid;
    logic [15:0] err_cnt;

    modport master (
        output enable, retrain, word, word_valid,
        input  phy_init, slip, state, link_up, fail,
        input  data, data_valid, err_cnt
    );

    modport slave (
        input  enable, retrain, word, word_valid,
        output phy_init, slip, state, link_up, fail,
        output data, data_valid, err_cnt
    );
endinterface

// File: rtl/serial_link_train.sv
// Word-alignment trainer: calibrate, settle, hunt a bit slip for PATTERN,
// confirm LOCK_WORDS matches, then forward aligned words while the link is up.
module serial_link_train #(
    parameter logic [63:0] PATTERN    = 64'h0123_4567_89AB_CDEF,
    parameter int unsigned CAL_LEN    = 4,
    parameter int unsigned SETTLE     = 64,
    parameter int unsigned LOCK_WORDS = 8,
    parameter int unsigned MAX_TRIES  = 3
) (
    input logic                clks,
    input logic                rsts,
    serial_link_train_if.slave lnk
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CAL    = 3'd1,
        S_SETTLE = 3'd2,
        S_HUNT   = 3'd3,
        S_LOCK   = 3'd4,
        S_UP     = 3'd5,
        S_FAIL   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic        phy_init_q, phy_init_d;
    logic [5:0]  slip_q, slip_d;
    logic        link_up_q, link_up_d;
    logic        fail_q, fail_d;
    logic [63:0] data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  good_q, good_d;
    logic [3:0]  sweep_q, sweep_d;

    logic [127:0] dbl;
    logic [63:0]  rot;
    logic         match;
    logic         miss;
    logic [3:0]   sweep_inc;
    logic [7:0]   good_inc;

    // Upper half of the doubled word shifted left is a rotate-left.
    assign dbl       = {lnk.word, lnk.word} << slip_q;
    assign rot       = dbl[127:64];
    assign match     = (rot == PATTERN);
    assign sweep_inc = sweep_q + 4'd1;
    assign good_inc  = good_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        phy_init_d   = phy_init_q;
        slip_d       = slip_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        err_cnt_d    = err_cnt_q;
        cnt_d        = cnt_q;
        good_d       = good_q;
        sweep_d      = sweep_q;
        miss         = 1'b0;

        if (!lnk.enable) begin
            state_d    = S_IDLE;
            phy_init_d = 1'b0;
            cnt_d      = '0;
            good_d     = '0;
            sweep_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d    = S_CAL;
                    phy_init_d = 1'b1;
                    cnt_d      = '0;
                    sweep_d    = '0;
                end
                S_CAL: begin
                    if (cnt_q == 16'(CAL_LEN - 1)) begin
                        state_d    = S_SETTLE;
                        phy_init_d = 1'b0;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 16'(SETTLE - 1)) begin
                        state_d = S_HUNT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_HUNT: begin
                    if (lnk.word_valid) begin
                        if (match) begin
                            good_d  = 8'd1;
                            state_d = (LOCK_WORDS == 1) ? S_UP : S_LOCK;
                        end else begin
                            miss = 1'b1;
                        end
                    end
                end
                S_LOCK: begin
                    if (lnk.word_valid) begin
                        if (match) begin
                            good_d = good_inc;
                            if (good_inc == 8'(LOCK_WORDS))
                                state_d = S_UP;
                        end else begin
                            miss = 1'b1;
                            if (err_cnt_q != 16'hFFFF)
                                err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                end
                S_UP: begin
                    if (lnk.word_valid) begin
                        data_d       = rot;
                        data_valid_d = 1'b1;
                    end
                    if (lnk.retrain) begin
                        state_d    = S_CAL;
                        phy_init_d = 1'b1;
                        cnt_d      = '0;
                        good_d     = '0;
                        sweep_d    = '0;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d    = S_IDLE;
                    phy_init_d = 1'b0;
                end
            endcase

            // A mismatch advances the slip; wrapping closes one full sweep.
            if (miss) begin
                slip_d  = slip_q + 6'd1;
                good_d  = '0;
                state_d = S_HUNT;
                if (slip_q == 6'd63) begin
                    sweep_d = sweep_inc;
                    cnt_d   = '0;
                    if (sweep_inc == 4'(MAX_TRIES)) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d    = S_CAL;
                        phy_init_d = 1'b1;
                    end
                end
            end
        end

        link_up_d = (state_d == S_UP);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge clks or posedge rsts) begin
        if (rsts) begin
            state_q      <= S_IDLE;
            phy_init_q   <= 1'b0;
            slip_q       <= '0;
            link_up_q    <= 1'b0;
            fail_q       <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            err_cnt_q    <= '0;
            cnt_q        <= '0;
            good_q       <= '0;
            sweep_q      <= '0;
        end else begin
            state_q      <= state_d;
            phy_init_q   <= phy_init_d;
            slip_q       <= slip_d;
            link_up_q    <= link_up_d;
            fail_q       <= fail_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            err_cnt_q    <= err_cnt_d;
            cnt_q        <= cnt_d;
            good_q       <= good_d;
            sweep_q      <= sweep_d;
        end
    end

    assign lnk.phy_init   = phy_init_q;
    assign lnk.slip       = slip_q;
    assign lnk.state      = state_q;
    assign lnk.link_up    = link_up_q;
    assign lnk.fail       = fail_q;
    assign lnk.data       = data_q;
    assign lnk.data_valid = data_valid_q;
    assign lnk.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_serial_link_train.sv
// Directed bench for serial_link_train with hand-computed expectations.
module tb_serial_link_train;

    localparam logic [63:0] PAT = 64'h0123_4567_89AB_CDEF;

    logic clks = 1'b0;
    logic rsts = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n;
    int   cal_pulses;
    logic prev_pi;
    logic [63:0] pat;
    logic [63:0] w13;

    serial_link_train_if lnk ();

    serial_link_train dut (
        .clks (clks),
        .rsts (rsts),
        .lnk  (lnk.slave)
    );

    always #5 clks = ~clks;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clks);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st,
                              input int budget);
        int k = 0;
        while (lnk.state !== st && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(lnk.state), 64'(st));
    endtask

    task automatic send(input logic [63:0] w);
        lnk.word       = w;
        lnk.word_valid = 1'b1;
        tick();
        lnk.word_valid = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        pat = PAT;
        w13 = {pat[12:0], pat[63:13]};
        lnk.enable = 1'b0;
        lnk.retrain = 1'b0;
        lnk.word = '0;
        lnk.word_valid = 1'b0;
        tick();
        tick();
        chk("rst_state", 64'(lnk.state), 64'd0);
        chk("rst_phy", 64'(lnk.phy_init), 64'd0);
        chk("rst_slip", 64'(lnk.slip), 64'd0);
        chk("rst_up", 64'(lnk.link_up), 64'd0);
        chk("rst_fail", 64'(lnk.fail), 64'd0);
        chk("rst_data", lnk.data, 64'd0);
        chk("rst_dv", 64'(lnk.data_valid), 64'd0);
        chk("rst_err", 64'(lnk.err_cnt), 64'd0);
        rsts = 1'b0;
        tick();
        chk("idle_hold", 64'(lnk.state), 64'd0);

        // Aligned link: 4 cal cycles, 64 settle cycles, up after 8 words.
        lnk.enable = 1'b1;
        tick();
        chk("cal_enter", 64'(lnk.state), 64'd1);
        n = 0;
        while (lnk.phy_init && n < 20) begin
            n++;
            tick();
        end
        chk("cal_len", 64'(n), 64'd4);
        chk("settle_enter", 64'(lnk.state), 64'd2);
        n = 0;
        while (lnk.state == 3'd2 && n < 200) begin
            n++;
            tick();
        end
        chk("settle_len", 64'(n), 64'd64);
        chk("hunt_enter", 64'(lnk.state), 64'd3);
        for (int k = 1; k <= 8; k++) begin
            send(PAT);
            if (k == 7)
                chk("lock_7", 64'(lnk.state), 64'd4);
            if (k < 8)
                repeat (31) tick();
        end
        chk("up_8", 64'(lnk.link_up), 64'd1);
        chk("up_slip", 64'(lnk.slip), 64'd0);
        send(PAT);
        chk("up_dv", 64'(lnk.data_valid), 64'd1);
        chk("up_data", lnk.data, PAT);
        tick();
        chk("up_dv_low", 64'(lnk.data_valid), 64'd0);

        // Retrain coinciding with a valid word.
        lnk.retrain = 1'b1;
        send(PAT);
        lnk.retrain = 1'b0;
        chk("rt_dv", 64'(lnk.data_valid), 64'd1);
        chk("rt_state", 64'(lnk.state), 64'd1);
        chk("rt_slip", 64'(lnk.slip), 64'd0);
        chk("rt_phy", 64'(lnk.phy_init), 64'd1);
        lnk.enable = 1'b0;
        tick();
        chk("dis_idle", 64'(lnk.state), 64'd0);
        chk("dis_phy", 64'(lnk.phy_init), 64'd0);

        // Word rotated right by 13: slip must walk to 13.
        lnk.enable = 1'b1;
        wait_state("hunt13", 3'd3, 200);
        repeat (13) send(w13);
        chk("slip13", 64'(lnk.slip), 64'd13);
        chk("hunt13_st", 64'(lnk.state), 64'd3);
        send(w13);
        chk("lock13", 64'(lnk.state), 64'd4);
        repeat (7) send(w13);
        chk("up13", 64'(lnk.state), 64'd5);
        send(w13);
        chk("data13", lnk.data, PAT);
        lnk.retrain = 1'b0;

        // Mismatch in LOCK after 5 good words.
        lnk.enable = 1'b0;
        tick();
        chk("slip_held", 64'(lnk.slip), 64'd13);
        lnk.enable = 1'b1;
        wait_state("hunt_e", 3'd3, 200);
        repeat (5) send(w13);
        chk("lock5", 64'(lnk.state), 64'd4);
        send(64'd0);
        chk("err1", 64'(lnk.err_cnt), 64'd1);
        chk("err_hunt", 64'(lnk.state), 64'd3);
        chk("err_slip", 64'(lnk.slip), 64'd14);

        // Garbage words: three sweeps end in FAIL.
        lnk.enable = 1'b0;
        tick();
        lnk.enable = 1'b1;
        lnk.word = 64'd0;
        lnk.word_valid = 1'b1;
        cal_pulses = 0;
        prev_pi = 1'b0;
        n = 0;
        while (!lnk.fail && n < 3000) begin
            tick();
            if (lnk.phy_init && !prev_pi)
                cal_pulses++;
            prev_pi = lnk.phy_init;
            n++;
        end
        chk("fail_flag", 64'(lnk.fail), 64'd1);
        chk("fail_cal", 64'(cal_pulses), 64'd3);
        chk("fail_st", 64'(lnk.state), 64'd6);
        chk("fail_slip", 64'(lnk.slip), 64'd0);
        repeat (5) tick();
        chk("fail_hold", 64'(lnk.state), 64'd6);
        lnk.word_valid = 1'b0;
        lnk.enable = 1'b0;
        tick();
        chk("fail_idle", 64'(lnk.state), 64'd0);
        chk("fail_clr", 64'(lnk.fail), 64'd0);
        chk("err_kept", 64'(lnk.err_cnt), 64'd1);

        // Async reset during the second calibration cycle.
        lnk.enable = 1'b1;
        tick();
        tick();
        chk("cal2_phy", 64'(lnk.phy_init), 64'd1);
        #2 rsts = 1'b1;
        #1;
        chk("ar_phy", 64'(lnk.phy_init), 64'd0);
        chk("ar_state", 64'(lnk.state), 64'd0);
        chk("ar_err", 64'(lnk.err_cnt), 64'd0);
        chk("ar_slip", 64'(lnk.slip), 64'd0);
        chk("ar_data", lnk.data, 64'd0);
        lnk.enable = 1'b0;
        tick();
        rsts = 1'b0;
        tick();
        chk("ar_wait", 64'(lnk.state), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
